seq_divider_param: RTL and testbench

//   Parametrised sequential restoring divider, next generation of the fixed 64/32 unit.

---
 rtl/seq_divider_param.sv | 168 ++++++++++++++++
 tb/tb_seq_divider_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_param.sv
// Sequential restoring divider, one quotient bit per clock.
// Operands are WIDTH bits; signed mode works on magnitudes and then corrects the
// signs of the results in a single fix-up cycle (truncating division, remainder
// takes the sign of the dividend). Divide-by-zero skips the iteration entirely.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   dividend, divisor   operands, sampled on accept
//   is_signed           two's-complement request (ignored when SIGNED_EN == 0)
//   out_valid/out_ready result handshake
//   quotient, remainder result; held until the next result is presented
//   div_by_zero         divisor was zero for the presented result
//   busy                unit is not idle
module seq_divider_param #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned REM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REM_W-1:0]   rem_w;      // partial remainder, one guard bit
    logic [WIDTH-1:0]   quo_w;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_mag;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_w;

    // Sign handling for the incoming request
    logic               sgn_c;
    logic               dvd_neg_c;
    logic               dvs_neg_c;
    logic [WIDTH-1:0]   dvd_mag_c;
    logic [WIDTH-1:0]   dvs_mag_c;

    always_comb begin
        sgn_c     = SIGNED_EN && is_signed;
        dvd_neg_c = sgn_c && dividend[WIDTH-1];
        dvs_neg_c = sgn_c && divisor[WIDTH-1];
        dvd_mag_c = dvd_neg_c ? WIDTH'(-dividend) : dividend;
        dvs_mag_c = dvs_neg_c ? WIDTH'(-divisor)  : divisor;
    end

    // One restoring step: shift in next dividend bit, trial-subtract the divisor
    logic [REM_W-1:0]   rem_shift_c;
    logic [REM_W-1:0]   rem_diff_c;
    logic               q_bit_c;

    always_comb begin
        rem_shift_c = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]};
        rem_diff_c  = rem_shift_c - {1'b0, dvs_mag};
        q_bit_c     = ~rem_diff_c[REM_W-1];
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_w       <= '0;
            quo_w       <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_w       <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        neg_q    <= dvd_neg_c ^ dvs_neg_c;
                        neg_r    <= dvd_neg_c;
                        dvs_mag  <= dvs_mag_c;
                        if (divisor == '0) begin
                            // Result is known immediately; dividend passes through untouched
                            quo_w <= '1;
                            rem_w <= {1'b0, dividend};
                            dbz_w <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo_w <= dvd_mag_c;
                            rem_w <= '0;
                            dbz_w <= 1'b0;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    quo_w <= {quo_w[WIDTH-2:0], q_bit_c};
                    if (q_bit_c) begin
                        rem_w <= rem_diff_c;
                    end else begin
                        rem_w <= rem_shift_c;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // Most-negative / -1 falls out here unchanged: magnitude quotient
                    // is 2^(WIDTH-1) and the signs agree, so no negation is applied.
                    if (neg_q) begin
                        quo_w <= WIDTH'(-quo_w);
                    end
                    if (neg_r) begin
                        rem_w <= {1'b0, WIDTH'(-rem_w[WIDTH-1:0])};
                    end
                    state <= DONE;
                end

                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        quotient    <= quo_w;
                        remainder   <= rem_w[WIDTH-1:0];
                        div_by_zero <= dbz_w;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed bench for seq_divider_param at WIDTH=32, signed mode enabled.
module tb_seq_divider_param;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    int n_checks;
    int n_fail;

    seq_divider_param #(
        .WIDTH    (WIDTH),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and let it be accepted on the next rising edge
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges elapsed since the accept edge until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic edz, input int elat);
        int lat;
        issue(a, b, s);
        wait_result(lat);
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"}, 64'(quotient), 64'(eq));
        check({tag, ".r"}, 64'(remainder), 64'(er));
        check({tag, ".dz"}, 64'(div_by_zero), 64'(edz));
        take_result();
        check({tag, ".ov_clr"}, 64'(out_valid), 64'd0);
        check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] held_q;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst.ov", 64'(out_valid), 64'd0);
        check("rst.q", 64'(quotient), 64'd0);
        check("rst.r", 64'(remainder), 64'd0);
        check("rst.dz", 64'(div_by_zero), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.rdy", 64'(in_ready), 64'd1);

        // Normal and signed cases
        run_op("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34);
        run_op("s-7_2",   32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34);
        run_op("s7_-2",   32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 34);
        run_op("s-7_-2",  32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0, 34);
        run_op("u-7_2",   32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, 34);
        run_op("u3_9",    32'd3,          32'd9,          1'b0, 32'd0,          32'd3,          1'b0, 34);

        // Divide by zero, both modes
        run_op("u5_0",    32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 1);
        run_op("s5_0",    32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1, 1);
        run_op("s-5_0",   32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1);

        // Signed overflow
        run_op("s_ovf",   32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 34);

        // Results hold in IDLE after transfer
        check("idle_hold.q", 64'(quotient), 64'h80000000);

        // Back-pressure: result held, new request not taken while in DONE
        issue(32'd1000, 32'd7, 1'b0);
        wait_result(lat);
        check("bp.lat", 64'(lat), 64'd34);
        held_q = quotient;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd10;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.ov", 64'(out_valid), 64'd1);
            check("bp.q", 64'(quotient), 64'(held_q));
            check("bp.r", 64'(remainder), 64'd6);
            check("bp.rdy", 64'(in_ready), 64'd0);
        end
        check("bp.q_val", 64'(held_q), 64'd142);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.xfer_ov", 64'(out_valid), 64'd0);
        check("bp.xfer_rdy", 64'(in_ready), 64'd1);
        check("bp.xfer_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.acc_rdy", 64'(in_ready), 64'd0);
        check("bp.acc_busy", 64'(busy), 64'd1);
        wait_result(lat);
        check("bp2.lat", 64'(lat), 64'd34);
        check("bp2.q", 64'(quotient), 64'd100);
        check("bp2.r", 64'(remainder), 64'd0);
        take_result();

        // Reset in the middle of RUN abandons the operation
        issue(32'd12345, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mrst.ov", 64'(out_valid), 64'd0);
        check("mrst.busy", 64'(busy), 64'd0);
        check("mrst.rdy", 64'(in_ready), 64'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("mrst.no_result", 64'(lat), 64'd0);
        run_op("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
